uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver; counterpart of the uart_tx frame format (start, 5-8 data bits LSB first, optional parity, stop).
// - Oversamples rxd on an external baud_clk pulse at 8x bit rate; emits each character on an AXI4-Stream source.
// - Sits between the pad-side rxd pin and the AES datapath byte stream; reports frame, parity and overrun errors.
// PARAMETERS
// - SYNC_STAGES  2  synchroniser flops on rxd (min 2)
// PORTS
// - Clk         in   1  system clock
// - Rst         in   1  reset, synchronous, active-high
// - En          in   1  block enable; low acts as reset
// - baud_clk    in   1  one-Clk pulse at 8x bit rate
// - m_axis      src  if taxi_axis_if; tdata[7:0], tvalid, tready
// - data_bits   in   2  0:8 1:7 2:6 3:5 bits
// - parity_en   in   1  1: parity bit expected
// - parity_type in   1  1: odd, 0: even
// - busy        out  1  frame in progress
// - frame_err   out  1  1-Clk pulse: stop bit sampled low
// - parity_err  out  1  1-Clk pulse: parity mismatch
// - overrun     out  1  1-Clk pulse: char lost, m_axis still full
// - noise_err   out  1  1-Clk pulse: sample disagreement (macro only, else 0)
// - rxd         in   1  serial input, idle high, asynchronous
// BEHAVIOUR
// - Reset (Rst | !En): state IDLE, tick/bit counters 0, tvalid 0, busy 0, all error pulses 0, sync chain all ones.
// - Counters advance only on Clk cycles with baud_clk=1; 3-bit tick counter, 8 ticks per bit.
// - FSM IDLE: synced rxd=0 on a tick -> START, tick cnt 0, busy=1.
// - START: at tick 4 sample; 1 -> false start, IDLE, busy=0, no pulse; 0 -> DATA.
// - DATA: sample every 8 ticks (bit centre), shift in LSB first; count = 8-data_bits; then PARITY if parity_en, else STOP.
// - PARITY: sampled bit vs ^data[n-1:0] (inverted if odd); mismatch latched.
// - STOP: one centre sample only; stop-bit count never checked, extra stop bits read as idle.
// - Stop sampled 1: tdata <= data zero-extended to 8 bits, tvalid=1 next Clk, parity_err pulse if latched -> IDLE.
// - Stop sampled 0: frame_err pulse, char discarded -> WAIT_IDLE; stays until synced rxd=1, then IDLE. Covers break.
// - Latency: tvalid rises 1 Clk after the stop-bit centre tick; busy falls same cycle.
// - tvalid held with tdata stable until tready; clears the cycle after tvalid&tready.
// - Completion while tvalid=1 and tready=0: new char dropped, held char kept, overrun pulse.
// - Completion in the same cycle as tvalid&tready: new char loaded, tvalid stays 1, no overrun.
// - Config inputs sampled at start detect, held internally for the whole frame.
// - Rst/En-low mid-frame aborts immediately; partial char is lost, no error pulse.
// CONFIGURATION
// - UART_RX_MAJORITY_EN defined: each bit, incl. start, sampled at ticks 3,4,5; majority-of-3 is the value.
//   Any disagreement pulses noise_err at the bit's decision tick. False-start check also uses majority.
// - Not defined: single sample at tick 4; noise_err tied 0.
// STRUCTURE
// - uart_pkg: data_bits encoding enum, rx FSM state enum, OVERSAMPLE=8, MID_TICK=4 constants.
// - Sub-module uart_rx_sampler: rxd synchroniser plus tick-phase sampler/majority voter.
//   Outputs the decided bit and a strobe; FSM stays in uart_rx.
// TESTING
// - 8N1 byte 0xA5, tready=1 -> tdata=0xA5, tvalid 1 Clk after stop centre; no error pulses.
// - 7E1 0x55 with correct, then flipped, parity bit -> 0x55 delivered both times; parity_err only on the second.
// - 8N1 0x3C with stop bit forced 0 -> frame_err pulse, no tvalid.
//   rxd held low 20 bits -> single frame_err, then re-arm after rxd=1.
// - 2-tick low glitch on idle rxd -> no busy beyond start check, no output.
// - Two 8N1 chars 0x11,0x22 with tready=0 -> tdata=0x11 held, overrun pulse at second stop.
//   tready then 1 -> 0x11 only.
// - UART_RX_MAJORITY_EN: single-tick inversion at tick 4 of bit 3 of 0xF0 -> 0xF0 received, noise_err pulse.
//   Mid-frame Rst -> idle outputs next Clk.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   - data_bits_e : encoding of the data_bits configuration input
//   - rx_state_e  : receiver FSM states
//   - OVERSAMPLE  : baud_clk ticks per bit
//   - MID_TICK    : tick index of the bit centre
//   - majority3   : 2-of-3 voter used by the optional noise filter
//   - parity_bit  : expected parity bit for a zero-extended character
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int         OVERSAMPLE = 8;
    localparam logic [2:0] MID_TICK   = 3'd4;

    typedef enum logic [1:0] {
        DBITS_8 = 2'd0,
        DBITS_7 = 2'd1,
        DBITS_6 = 2'd2,
        DBITS_5 = 2'd3
    } data_bits_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Unused upper bits of the character are zero, so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// ---------------------------------------------------------------------------
// taxi_axis_if
// Minimal AXI4-Stream interface (tdata/tvalid/tready).
//   modport src : drives tdata, tvalid; receives tready
//   modport snk : receives tdata, tvalid; drives tready
// ---------------------------------------------------------------------------
interface taxi_axis_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, output tvalid, input tready);
    modport snk (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// rxd synchroniser plus bit-centre sampler for the UART receiver.
// Build option: UART_RX_MAJORITY_EN
//   defined   : each bit is sampled at ticks 3,4,5; the 2-of-3 vote is the
//               bit value, decided at tick 5; any disagreement raises o_noise.
//   undefined : single sample at tick 4; o_noise is constant 0.
// Ports:
//   Clk, Rst    clock, synchronous active-high reset
//   i_clr       receiver clear (Rst or block disabled)
//   i_rxd       asynchronous serial input, idle high
//   i_tick_en   baud tick while a frame is being received
//   i_tick      tick index (0..7) within the current bit for this tick
//   o_rxd_sync  synchronised rxd
//   o_strobe    bit decision is valid this cycle
//   o_bit       decided bit value
//   o_noise     samples of this bit disagreed (qualified by o_strobe)
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_clr,
    input  logic       i_rxd,
    input  logic       i_tick_en,
    input  logic [2:0] i_tick,
    output logic       o_rxd_sync,
    output logic       o_strobe,
    output logic       o_bit,
    output logic       o_noise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxd;

    // Synchroniser chain; resets to idle-high so a reset never looks like a start bit.
    always_ff @(posedge Clk) begin
        if (Rst || i_clr) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
        end
    end

    assign w_rxd      = r_sync[SYNC_STAGES-1];
    assign o_rxd_sync = w_rxd;

`ifdef UART_RX_MAJORITY_EN
    logic r_s3;
    logic r_s4;

    // Capture the two early samples; the third is the live value at the decision tick.
    always_ff @(posedge Clk) begin
        if (Rst || i_clr) begin
            r_s3 <= 1'b1;
            r_s4 <= 1'b1;
        end else if (i_tick_en) begin
            if (i_tick == (MID_TICK - 3'd1)) begin
                r_s3 <= w_rxd;
            end
            if (i_tick == MID_TICK) begin
                r_s4 <= w_rxd;
            end
        end
    end

    assign o_strobe = i_tick_en && (i_tick == (MID_TICK + 3'd1));
    assign o_bit    = majority3(r_s3, r_s4, w_rxd);
    assign o_noise  = !((r_s3 == r_s4) && (r_s4 == w_rxd));
`else
    assign o_strobe = i_tick_en && (i_tick == MID_TICK);
    assign o_bit    = w_rxd;
    assign o_noise  = 1'b0;
`endif

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: start, 5-8 data bits LSB first, optional parity, stop.
// rxd is oversampled on baud_clk (8 ticks per bit); characters leave on an
// AXI4-Stream source. Frame, parity and overrun errors are 1-Clk pulses.
// Build option: UART_RX_MAJORITY_EN enables 3-sample majority voting and the
// noise_err pulse; without it noise_err is always 0.
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   En           block enable, low acts as reset
//   baud_clk     one-Clk pulse at 8x bit rate
//   m_axis       AXI4-Stream source, tdata[7:0] zero-extended character
//   data_bits    0:8 1:7 2:6 3:5 data bits
//   parity_en    parity bit expected
//   parity_type  1 odd, 0 even
//   busy         frame in progress
//   frame_err    stop bit sampled low
//   parity_err   parity mismatch on a delivered character
//   overrun      character dropped because m_axis was still full
//   noise_err    samples within a bit disagreed
//   rxd          serial input, idle high, asynchronous
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            En,
    input  logic            baud_clk,
    taxi_axis_if.src        m_axis,
    input  logic [1:0]      data_bits,
    input  logic            parity_en,
    input  logic            parity_type,
    output logic            busy,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun,
    output logic            noise_err,
    input  logic            rxd
);

    rx_state_e  r_state;
    logic [2:0] r_tick;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    data_bits_e r_data_bits;
    logic       r_parity_en;
    logic       r_parity_type;
    logic       r_par_err;
    logic [7:0] r_tdata;
    logic       r_tvalid;
    logic       r_busy;
    logic       r_frame_err;
    logic       r_parity_err;
    logic       r_overrun;
    logic       r_noise_err;

    logic       w_clr;
    logic       w_active;
    logic       w_tick_en;
    logic [2:0] w_tick;
    logic [2:0] w_last_bit;
    logic       w_rxd_sync;
    logic       w_strobe;
    logic       w_bit;
    logic       w_noise;

    assign w_clr      = Rst || !En;
    assign w_active   = (r_state == ST_START) || (r_state == ST_DATA) ||
                        (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_tick_en  = baud_clk && w_active;
    // Tick index of the current baud pulse; the start-detect pulse is tick 0.
    assign w_tick     = r_tick + 3'd1;
    assign w_last_bit = 3'd7 - {1'b0, r_data_bits};

    uart_rx_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_clr      (w_clr),
        .i_rxd      (rxd),
        .i_tick_en  (w_tick_en),
        .i_tick     (w_tick),
        .o_rxd_sync (w_rxd_sync),
        .o_strobe   (w_strobe),
        .o_bit      (w_bit),
        .o_noise    (w_noise)
    );

    // Receiver FSM, output stream register and error pulses.
    always_ff @(posedge Clk) begin
        if (w_clr) begin
            r_state       <= ST_IDLE;
            r_tick        <= 3'd0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_data_bits   <= DBITS_8;
            r_parity_en   <= 1'b0;
            r_parity_type <= 1'b0;
            r_par_err     <= 1'b0;
            r_tdata       <= 8'd0;
            r_tvalid      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun     <= 1'b0;
            r_noise_err   <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_noise_err  <= w_strobe && w_noise;

            if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_tick_en) begin
                r_tick <= w_tick;
            end

            case (r_state)
                ST_IDLE: begin
                    if (baud_clk && !w_rxd_sync) begin
                        r_state       <= ST_START;
                        r_tick        <= 3'd0;
                        r_bit_cnt     <= 3'd0;
                        r_shift       <= 8'd0;
                        r_par_err     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_data_bits   <= data_bits_e'(data_bits);
                        r_parity_en   <= parity_en;
                        r_parity_type <= parity_type;
                    end
                end
                ST_START: begin
                    if (w_strobe) begin
                        if (w_bit) begin
                            // Line back high at the centre: glitch, not a start bit.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        r_shift[r_bit_cnt] <= w_bit;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state <= r_parity_en ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_strobe) begin
                        r_par_err <= (w_bit != parity_bit(r_shift, r_parity_type));
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_strobe) begin
                        r_busy <= 1'b0;
                        if (w_bit) begin
                            r_parity_err <= r_par_err;
                            // A handshake this cycle frees the slot, so only a
                            // stalled sink causes an overrun.
                            if (r_tvalid && !m_axis.tready) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_tdata  <= r_shift;
                                r_tvalid <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // Hold off through a break until the line returns high.
                    if (w_rxd_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign busy          = r_busy;
    assign frame_err     = r_frame_err;
    assign parity_err    = r_parity_err;
    assign overrun       = r_overrun;
    assign noise_err     = r_noise_err;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. baud_clk pulses every 4 Clk; the line is
// driven one baud slot at a time, 8 slots per bit. A monitor records every
// delivered character and counts error pulses; each test compares those
// against a reference model computed from the frame format.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       En = 1'b1;
    logic       baud_clk = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] data_bits = 2'd0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       noise_err;

    taxi_axis_if #(.DATA_W(8)) axis_if ();

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         frame_cnt = 0;
    int         par_cnt = 0;
    int         ovr_cnt = 0;
    int         noise_cnt = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .baud_clk    (baud_clk),
        .m_axis      (axis_if),
        .data_bits   (data_bits),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .noise_err   (noise_err),
        .rxd         (rxd)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            repeat (3) @(posedge Clk);
            #1 baud_clk = 1'b1;
            @(posedge Clk);
            #1 baud_clk = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (axis_if.tvalid && axis_if.tready) rx_q.push_back(axis_if.tdata);
        if (frame_err)  frame_cnt++;
        if (parity_err) par_cnt++;
        if (overrun)    ovr_cnt++;
        if (noise_err)  noise_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: character as delivered, and the correct parity bit.
    function automatic logic [7:0] model_char(input logic [7:0] d, input int nb);
        return 8'(int'(d) % (1 << nb));
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input int nb, input logic odd);
        return 1'(($countones(model_char(d, nb)) + int'(odd)) % 2);
    endfunction

    // Drive one level for the next baud pulse and return just after it.
    task automatic slot(input logic lvl);
        rxd = lvl;
        @(posedge Clk);
        while (baud_clk !== 1'b1) @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) slot(1'b1);
    endtask

    // Send a frame; the last bit is cut after last_slots slots, one slot of
    // one bit may be inverted for noise injection.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic podd, input logic flip, input logic stop,
                              input int inv_bit, input int last_slots);
        logic lv[$];
        logic lvl;
        lv.push_back(1'b0);
        for (int i = 0; i < nb; i++) lv.push_back(d[i]);
        if (pen) lv.push_back(model_parity(d, nb, podd) ^ flip);
        lv.push_back(stop);
        data_bits   = 2'(8 - nb);
        parity_en   = pen;
        parity_type = podd;
        for (int b = 0; b < lv.size(); b++) begin
            for (int s = 0; s < ((b == lv.size() - 1) ? last_slots : 8); s++) begin
                lvl = lv[b];
                if (b == inv_bit && s == 4) lvl = ~lvl;
                slot(lvl);
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        En  = 1'b1;
        rxd = 1'b1;
        axis_if.tready = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        checks++;
        if (axis_if.tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got tvalid=%b busy=%b expected 0 0", axis_if.tvalid, busy);
        end
        checks++;
        if ({frame_err, parity_err, overrun, noise_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_errs: got %b expected 0000", {frame_err, parity_err, overrun, noise_err});
        end
        Rst = 1'b0;
        idle(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_8n1();
        int q0 = rx_q.size();
        int f0 = frame_cnt, p0 = par_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4);
        checks++;
        if (axis_if.tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL 8n1_pre_stop: got tvalid=%b busy=%b expected 0 1", axis_if.tvalid, busy);
        end
        slot(1'b1);
        checks++;
        if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== 8'hA5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_latency: got tvalid=%b tdata=%h busy=%b expected 1 a5 0",
                     axis_if.tvalid, axis_if.tdata, busy);
        end
        idle(5);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hA5) begin
            errors++;
            $display("FAIL 8n1_data: got %0d chars expected 1 char a5", rx_q.size() - q0);
        end
        checks++;
        if (frame_cnt != f0 || par_cnt != p0) begin
            errors++;
            $display("FAIL 8n1_errs: got frame=%0d parity=%0d expected 0 0", frame_cnt - f0, par_cnt - p0);
        end
    endtask

    task automatic test_parity();
        int q0 = rx_q.size();
        int p0 = par_cnt;
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b0, 1'b1, -1, 8);
        idle(2);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'h55 || par_cnt != p0) begin
            errors++;
            $display("FAIL 7e1_good: got %0d chars parity=%0d expected 1 char 55 parity 0",
                     rx_q.size() - q0, par_cnt - p0);
        end
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8);
        idle(2);
        checks++;
        if (rx_q.size() != q0 + 2 || rx_q[q0 + 1] !== 8'h55 || par_cnt != p0 + 1) begin
            errors++;
            $display("FAIL 7e1_bad: got %0d chars parity=%0d expected 2 chars 55 parity 1",
                     rx_q.size() - q0, par_cnt - p0);
        end
    endtask

    task automatic test_frame_err();
        int q0 = rx_q.size();
        int f0 = frame_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8);
        idle(8);
        checks++;
        if (frame_cnt != f0 + 1 || rx_q.size() != q0) begin
            errors++;
            $display("FAIL frame_stop0: got frame=%0d chars=%0d expected 1 0", frame_cnt - f0, rx_q.size() - q0);
        end
        repeat (160) slot(1'b0);
        idle(8);
        checks++;
        if (frame_cnt != f0 + 2 || rx_q.size() != q0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL break: got frame=%0d chars=%0d busy=%b expected 2 0 0",
                     frame_cnt - f0, rx_q.size() - q0, busy);
        end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8);
        idle(2);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'h5A) begin
            errors++;
            $display("FAIL rearm: got %0d chars expected 1 char 5a", rx_q.size() - q0);
        end
    endtask

    task automatic test_glitch();
        int q0 = rx_q.size();
        int f0 = frame_cnt;
        slot(1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_detect: got busy=%b expected 1", busy);
        end
        slot(1'b0);
        idle(6);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got busy=%b expected 0", busy);
        end
        idle(80);
        checks++;
        if (rx_q.size() != q0 || frame_cnt != f0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_output: got chars=%0d frame=%0d expected 0 0", rx_q.size() - q0, frame_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        int q0 = rx_q.size();
        int o0 = ovr_cnt;
        axis_if.tready = 1'b0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8);
        checks++;
        if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== 8'h11 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL ovr_first: got tvalid=%b tdata=%h ovr=%0d expected 1 11 0",
                     axis_if.tvalid, axis_if.tdata, ovr_cnt - o0);
        end
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8);
        checks++;
        if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== 8'h11 || ovr_cnt != o0 + 1) begin
            errors++;
            $display("FAIL ovr_second: got tvalid=%b tdata=%h ovr=%0d expected 1 11 1",
                     axis_if.tvalid, axis_if.tdata, ovr_cnt - o0);
        end
        axis_if.tready = 1'b1;
        idle(4);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'h11 || axis_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: got %0d chars tvalid=%b expected 1 char 11 tvalid 0",
                     rx_q.size() - q0, axis_if.tvalid);
        end
    endtask

    task automatic test_abort();
        int q0 = rx_q.size();
        int f0 = frame_cnt;
        for (int k = 0; k < 2; k++) begin
            repeat (8) slot(1'b0);
            repeat (4) slot(1'b1);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_busy_before_%0d: got %b expected 1", k, busy);
            end
            rxd = 1'b1;
            if (k == 0) Rst = 1'b1;
            else        En  = 1'b0;
            @(posedge Clk);
            #1;
            checks++;
            if (busy !== 1'b0 || axis_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle_%0d: got busy=%b tvalid=%b expected 0 0", k, busy, axis_if.tvalid);
            end
            Rst = 1'b0;
            En  = 1'b1;
            idle(100);
        end
        checks++;
        if (rx_q.size() != q0 || frame_cnt != f0) begin
            errors++;
            $display("FAIL abort_silent: got chars=%0d frame=%0d expected 0 0", rx_q.size() - q0, frame_cnt - f0);
        end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8);
        idle(2);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hC3) begin
            errors++;
            $display("FAIL abort_recover: got %0d chars expected 1 char c3", rx_q.size() - q0);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_noise();
        int q0 = rx_q.size();
        int n0 = noise_cnt;
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8);
        idle(2);
        checks++;
        if (rx_q.size() != q0 + 1 || rx_q[q0] !== 8'hF0 || noise_cnt != n0 + 1) begin
            errors++;
            $display("FAIL noise: got %0d chars noise=%0d expected 1 char f0 noise 1",
                     rx_q.size() - q0, noise_cnt - n0);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int q0 = rx_q.size();
        int f0 = frame_cnt, p0 = par_cnt, n0 = noise_cnt, o0 = ovr_cnt;
        int exp_frame = 0, exp_par = 0;
        int nb;
        logic pen, podd, flip, stop_ok;
        for (int f = 0; f < 30; f++) begin
            d       = 8'($urandom);
            nb      = int'($urandom_range(5, 8));
            pen     = 1'($urandom_range(0, 1));
            podd    = 1'($urandom_range(0, 1));
            flip    = pen && ($urandom_range(0, 3) == 0);
            stop_ok = ($urandom_range(0, 7) != 0);
            send_frame(d, nb, pen, podd, flip, stop_ok, -1, 8);
            if (stop_ok) begin
                exp_q.push_back(model_char(d, nb));
                if (flip) exp_par++;
            end else begin
                exp_frame++;
            end
            idle(int'($urandom_range(stop_ok ? 0 : 1, 12)));
        end
        idle(4);
        checks++;
        if (rx_q.size() - q0 != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d chars expected %0d", rx_q.size() - q0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[q0 + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_char_%0d: got %h expected %h", i, rx_q[q0 + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (frame_cnt - f0 != exp_frame || par_cnt - p0 != exp_par) begin
            errors++;
            $display("FAIL b2b_errs: got frame=%0d parity=%0d expected %0d %0d",
                     frame_cnt - f0, par_cnt - p0, exp_frame, exp_par);
        end
        checks++;
        if (noise_cnt != n0 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL b2b_noise_ovr: got noise=%0d ovr=%0d expected 0 0", noise_cnt - n0, ovr_cnt - o0);
        end
    endtask

    initial begin
        axis_if.tready = 1'b1;
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_abort();
`ifdef UART_RX_MAJORITY_EN
        test_noise();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
